instr_field_stage: RTL and testbench

- Pipeline stage between instruction fetch and decode/sign-extension in the Mini-CPU.
- Registers each fetched 32-bit MIPS instruction and its PC, then splits the instruction into fields.
- out_immed drives the 16-bit immediate input of the sign extender directly.
- Uses a valid/ready handshake on both sides, with a 2-entry skid buffer, so stalls never drop or duplicate an instruction.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/instr_field_split.sv | 24 ++
 rtl/instr_field_stage.sv | 121 ++++++++++++
 tb/tb_instr_field_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared Mini-CPU definitions: MIPS instruction field positions and the
// decoded-field bundle used by the field stage and the decode stage.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned JT_MSB    = 25;
  localparam int unsigned JT_LSB    = 0;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immed;
    logic [25:0] jtarget;
    logic        is_rtype;
    logic        is_nop;
  } instr_fields_t;

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational split of a 32-bit MIPS word into its field bundle;
// shared by the field stage and the decode stage.
module instr_field_split
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output instr_fields_t      fields_o
);

  always_comb begin
    fields_o          = '0;
    fields_o.opcode   = instr_i[OPC_MSB:OPC_LSB];
    fields_o.rs       = instr_i[RS_MSB:RS_LSB];
    fields_o.rt       = instr_i[RT_MSB:RT_LSB];
    fields_o.rd       = instr_i[RD_MSB:RD_LSB];
    fields_o.shamt    = instr_i[SHAMT_MSB:SHAMT_LSB];
    fields_o.funct    = instr_i[FUNCT_MSB:FUNCT_LSB];
    fields_o.immed    = instr_i[IMM_MSB:IMM_LSB];
    fields_o.jtarget  = instr_i[JT_MSB:JT_LSB];
    fields_o.is_rtype = (instr_i[OPC_MSB:OPC_LSB] == OPC_RTYPE);
    fields_o.is_nop   = (instr_i == '0);
  end

endmodule

// File: rtl/instr_field_stage.sv
// Fetch-to-decode pipeline register with a 2-entry skid buffer; the held
// instruction is split into MIPS fields combinationally on the output side.
module instr_field_stage
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [PC_W-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [5:0]          out_opcode,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_shamt,
  output logic [5:0]          out_funct,
  output logic [15:0]         out_immed,
  output logic [25:0]         out_jtarget,
  output logic                out_is_rtype,
  output logic                out_is_nop
);

  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic               skid_valid_q, skid_valid_d;

  logic          accept;
  logic          main_free;
  instr_fields_t fields;

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign main_free = ~out_valid_q | out_ready;

  // NOTE: every variable gets a hold default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        out_instr_d = skid_instr_q;
        out_pc_d    = skid_pc_q;
        out_valid_d = 1'b1;
        if (accept) begin
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end
        skid_valid_d = accept;
      end else if (accept) begin
        out_instr_d = in_instr;
        out_pc_d    = in_pc;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample
  // the same pre-edge values; data registers are reset too so the field
  // outputs are defined (all zero, a NOP) straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  instr_field_split u_split (
    .instr_i  (out_instr_q),
    .fields_o (fields)
  );

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_opcode   = fields.opcode;
  assign out_rs       = fields.rs;
  assign out_rt       = fields.rt;
  assign out_rd       = fields.rd;
  assign out_shamt    = fields.shamt;
  assign out_funct    = fields.funct;
  assign out_immed    = fields.immed;
  assign out_jtarget  = fields.jtarget;
  assign out_is_rtype = fields.is_rtype;
  assign out_is_nop   = fields.is_nop;

endmodule

// File: tb/tb_instr_field_stage.sv
// Directed bench for instr_field_stage: reset, single pass, backpressure,
// flush, streaming and asynchronous reset with both entries occupied.
module tb_instr_field_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_immed;
  logic [25:0] out_jtarget;
  logic        out_is_rtype;
  logic        out_is_nop;

  int n_checks = 0;
  int n_fail   = 0;

  instr_field_stage #(.PC_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_opcode   (out_opcode),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_shamt    (out_shamt),
    .out_funct    (out_funct),
    .out_immed    (out_immed),
    .out_jtarget  (out_jtarget),
    .out_is_rtype (out_is_rtype),
    .out_is_nop   (out_is_nop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge, then inputs change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_immed", out_immed, 0);
    check("rst_pc", out_pc, 0);
    check("rst_is_rtype", out_is_rtype, 1);
    check("rst_is_nop", out_is_nop, 1);
    rst_n = 1'b1;
    tick();

    // Single pass: addi $8,$9,-4
    out_ready = 1'b1;
    drive(1'b1, 32'h2128FFFC, 32'h40);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("sp_valid", out_valid, 1);
    check("sp_opcode", out_opcode, 6'h08);
    check("sp_rs", out_rs, 9);
    check("sp_rt", out_rt, 8);
    check("sp_immed", out_immed, 16'hFFFC);
    check("sp_jtarget", out_jtarget, 26'h128FFFC);
    check("sp_pc", out_pc, 32'h40);
    check("sp_is_rtype", out_is_rtype, 0);
    check("sp_is_nop", out_is_nop, 0);
    tick();
    check("sp_drained", out_valid, 0);

    // Backpressure: A = add $8,$9,$10, B = lw $9,4($8), C = sw $10,8($0)
    out_ready = 1'b0;
    drive(1'b1, 32'h012A4020, 32'h100);
    tick();
    check("bp_a_valid", out_valid, 1);
    check("bp_a_in_ready", in_ready, 1);
    drive(1'b1, 32'h8D090004, 32'h104);
    tick();
    check("bp_skid_full", in_ready, 0);
    check("bp_a_pc", out_pc, 32'h100);
    check("bp_a_opcode", out_opcode, 6'h00);
    check("bp_a_rs", out_rs, 9);
    check("bp_a_rt", out_rt, 10);
    check("bp_a_rd", out_rd, 8);
    check("bp_a_shamt", out_shamt, 0);
    check("bp_a_funct", out_funct, 6'h20);
    check("bp_a_rtype", out_is_rtype, 1);
    drive(1'b1, 32'hAC0A0008, 32'h108);
    tick();
    check("bp_c_refused", in_ready, 0);
    check("bp_hold_pc", out_pc, 32'h100);
    check("bp_hold_immed", out_immed, 16'h4020);
    out_ready = 1'b1;
    tick();
    check("bp_b_valid", out_valid, 1);
    check("bp_b_pc", out_pc, 32'h104);
    check("bp_b_opcode", out_opcode, 6'h23);
    check("bp_b_ready", in_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("bp_c_valid", out_valid, 1);
    check("bp_c_pc", out_pc, 32'h108);
    check("bp_c_opcode", out_opcode, 6'h2B);
    check("bp_c_immed", out_immed, 16'h0008);
    tick();
    check("bp_no_dup", out_valid, 0);

    // Flush with skid full and a simultaneous offered word D
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 32'h200);
    tick();
    drive(1'b1, 32'h22222222, 32'h204);
    tick();
    check("fl_skid_full", in_ready, 0);
    check("fl_main_valid", out_valid, 1);
    flush = 1'b1;
    drive(1'b1, 32'h33333333, 32'h208);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_data_kept", out_pc, 32'h200);
    out_ready = 1'b1;
    tick();
    check("fl_d_gone", out_valid, 0);

    // Streaming: 8 back-to-back words
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h20000000 | 32'(i), 32'h300 + 32'(4 * i));
      check($sformatf("st_in_ready_%0d", i), in_ready, 1);
      tick();
      check($sformatf("st_valid_%0d", i), out_valid, 1);
      check($sformatf("st_pc_%0d", i), out_pc, 32'h300 + 32'(4 * i));
      check($sformatf("st_immed_%0d", i), out_immed, 32'(i));
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("st_drained", out_valid, 0);

    // Asynchronous reset with main and skid both full
    out_ready = 1'b0;
    drive(1'b1, 32'h2128FFFC, 32'h400);
    tick();
    drive(1'b1, 32'h012A4020, 32'h404);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("ar_pre_valid", out_valid, 1);
    check("ar_pre_skid", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_immed", out_immed, 0);
    check("ar_is_nop", out_is_nop, 1);
    #3;
    rst_n = 1'b1;
    tick();
    check("ar_after_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
